// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch stage: state encoding,
// end-of-program word and default address width.
package fetch_pkg;
   localparam int FETCH_ADDR_W = 5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   localparam logic [31:0] HALT_WORD = 32'h0000_0000;
endpackage

// File: rtl/instruction_fetch.sv
// Single-stage instruction fetch: drives the PC to memory, registers the
// returned word toward decode with a valid/ready handshake, redirect and halt.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter int ADDRESS_WIDTH = FETCH_ADDR_W
) (
   input  logic                     fetch_clk,
   input  logic                     fetch_rst,
   output logic [ADDRESS_WIDTH-1:0] fetch_addr,
   input  logic [31:0]              fetch_instr_in,
   output logic [31:0]              fetch_instr_out,
   output logic [ADDRESS_WIDTH-1:0] fetch_pc_out,
   output logic                     fetch_valid,
   input  logic                     fetch_ready,
   input  logic                     fetch_redirect,
   input  logic [ADDRESS_WIDTH-1:0] fetch_redirect_addr,
   output logic                     fetch_halted
);

   logic [1:0]               r_state;
   logic [ADDRESS_WIDTH-1:0] r_pc;
   logic [31:0]              r_instr;
   logic [ADDRESS_WIDTH-1:0] r_pc_out;
   logic                     r_valid;

   logic                     w_load;
   logic [ADDRESS_WIDTH-1:0] w_pc_next;

   // The output register may take a new word when empty or being consumed.
   assign w_load    = !r_valid || fetch_ready;
   assign w_pc_next = r_pc + 1'b1;

   always_ff @(posedge fetch_clk) begin
      if (fetch_rst) begin
         r_state  <= ST_IDLE;
         r_pc     <= '0;
         r_instr  <= '0;
         r_pc_out <= '0;
         r_valid  <= 1'b0;
      end else if (fetch_redirect) begin
         // Redirect flushes the held word even if decode is stalling.
         r_pc    <= fetch_redirect_addr;
         r_valid <= 1'b0;
         r_state <= ST_RUN;
      end else begin
         case (r_state)
            ST_IDLE: r_state <= ST_RUN;
            ST_RUN: begin
               if (w_load) begin
                  if (fetch_instr_in == HALT_WORD) begin
                     r_valid <= 1'b0;
                     r_state <= ST_HALT;
                  end else begin
                     r_instr  <= fetch_instr_in;
                     r_pc_out <= r_pc;
                     r_valid  <= 1'b1;
                     r_pc     <= w_pc_next;
                  end
               end
            end
            ST_HALT: r_valid <= 1'b0;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign fetch_addr      = r_pc;
   assign fetch_instr_out = r_instr;
   assign fetch_pc_out    = r_pc_out;
   assign fetch_valid     = r_valid;
   assign fetch_halted    = (r_state == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: accepted words are checked against
// an expected-order queue; control behaviour is checked cycle by cycle.
module tb_instruction_fetch;
   logic        fetch_clk = 1'b0;
   logic        fetch_rst;
   logic [4:0]  fetch_addr;
   logic [31:0] fetch_instr_in;
   logic [31:0] fetch_instr_out;
   logic [4:0]  fetch_pc_out;
   logic        fetch_valid;
   logic        fetch_ready;
   logic        fetch_redirect;
   logic [4:0]  fetch_redirect_addr;
   logic        fetch_halted;

   logic [31:0] mem [32];
   logic [36:0] exp_q [$];
   int          n_tests = 0;
   int          n_fail  = 0;

   instruction_fetch #(.ADDRESS_WIDTH(5)) dut (
      .fetch_clk          (fetch_clk),
      .fetch_rst          (fetch_rst),
      .fetch_addr         (fetch_addr),
      .fetch_instr_in     (fetch_instr_in),
      .fetch_instr_out    (fetch_instr_out),
      .fetch_pc_out       (fetch_pc_out),
      .fetch_valid        (fetch_valid),
      .fetch_ready        (fetch_ready),
      .fetch_redirect     (fetch_redirect),
      .fetch_redirect_addr(fetch_redirect_addr),
      .fetch_halted       (fetch_halted)
   );

   always #5 fetch_clk = ~fetch_clk;

   assign fetch_instr_in = mem[fetch_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge fetch_clk);
      #2;
   endtask

   task automatic push_range(input int lo, input int n);
      for (int i = 0; i < n; i++) begin
         logic [4:0] a;
         a = 5'((lo + i) % 32);
         exp_q.push_back({a, mem[a]});
      end
   endtask

   task automatic wait_halt(input int max_cyc, input string name);
      for (int i = 0; i < max_cyc && !fetch_halted; i++) cyc();
      chk(name, 32'(fetch_halted), 32'd1);
   endtask

   // Scoreboard monitor: every accepted word must be the next expected one.
   always @(negedge fetch_clk) begin
      if (!fetch_rst && fetch_valid && fetch_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected: got pc %0d instr %h, nothing expected", fetch_pc_out, fetch_instr_out);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            chk("sb_pc", 32'(fetch_pc_out), 32'(e[36:32]));
            chk("sb_instr", fetch_instr_out, e[31:0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
      mem[7] = 32'h0;
      fetch_rst = 1'b1;
      fetch_ready = 1'b1;
      fetch_redirect = 1'b0;
      fetch_redirect_addr = '0;

      // Reset held two cycles
      cyc();
      cyc();
      chk("rst_addr", 32'(fetch_addr), 32'd0);
      chk("rst_valid", 32'(fetch_valid), 32'd0);
      chk("rst_halted", 32'(fetch_halted), 32'd0);
      chk("rst_pc_out", 32'(fetch_pc_out), 32'd0);
      chk("rst_instr", fetch_instr_out, 32'd0);
      push_range(0, 7);
      fetch_rst = 1'b0;
      cyc();
      chk("idle_valid", 32'(fetch_valid), 32'd0);
      chk("idle_addr", 32'(fetch_addr), 32'd0);

      // Back-to-back stream 0..6 then halt at word 7
      cyc();
      for (int k = 0; k < 7; k++) begin
         chk("stream_valid", 32'(fetch_valid), 32'd1);
         chk("stream_pc", 32'(fetch_pc_out), 32'(k));
         if (k < 6) cyc();
      end
      cyc();
      chk("halt_valid", 32'(fetch_valid), 32'd0);
      chk("halt_flag", 32'(fetch_halted), 32'd1);
      chk("halt_addr", 32'(fetch_addr), 32'd7);
      cyc();
      chk("halt_hold_addr", 32'(fetch_addr), 32'd7);
      chk("halt_hold_valid", 32'(fetch_valid), 32'd0);

      // Redirect to 31 and wrap to 0
      push_range(31, 8);
      fetch_redirect = 1'b1;
      fetch_redirect_addr = 5'd31;
      cyc();
      fetch_redirect = 1'b0;
      chk("wrap_rd_valid", 32'(fetch_valid), 32'd0);
      chk("wrap_rd_addr", 32'(fetch_addr), 32'd31);
      chk("wrap_rd_halted", 32'(fetch_halted), 32'd0);
      cyc();
      chk("wrap_pc31", 32'(fetch_pc_out), 32'd31);
      cyc();
      chk("wrap_pc0", 32'(fetch_pc_out), 32'd0);
      wait_halt(20, "wrap_halt");

      // Stall three cycles while pc_out=2
      fetch_rst = 1'b1;
      cyc();
      cyc();
      fetch_rst = 1'b0;
      push_range(0, 7);
      cyc();
      cyc();
      cyc();
      cyc();
      chk("stall_pre_pc", 32'(fetch_pc_out), 32'd2);
      fetch_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         cyc();
         chk("stall_valid", 32'(fetch_valid), 32'd1);
         chk("stall_pc", 32'(fetch_pc_out), 32'd2);
         chk("stall_instr", fetch_instr_out, mem[2]);
         chk("stall_addr", 32'(fetch_addr), 32'd3);
      end
      fetch_ready = 1'b1;
      cyc();
      chk("stall_resume_pc", 32'(fetch_pc_out), 32'd3);
      wait_halt(20, "stall_halt");

      // Redirect to 14 while pc_out=5 and decode stalled
      push_range(0, 5);
      push_range(14, 25);
      fetch_redirect = 1'b1;
      fetch_redirect_addr = 5'd0;
      cyc();
      fetch_redirect = 1'b0;
      for (int s = 0; s < 6; s++) cyc();
      chk("rd_pre_pc", 32'(fetch_pc_out), 32'd5);
      fetch_ready = 1'b0;
      fetch_redirect = 1'b1;
      fetch_redirect_addr = 5'd14;
      cyc();
      chk("rd_flush_valid", 32'(fetch_valid), 32'd0);
      chk("rd_addr", 32'(fetch_addr), 32'd14);
      fetch_redirect = 1'b0;
      fetch_ready = 1'b1;
      cyc();
      chk("rd_valid", 32'(fetch_valid), 32'd1);
      chk("rd_pc", 32'(fetch_pc_out), 32'd14);
      chk("rd_instr", fetch_instr_out, mem[14]);
      wait_halt(40, "rd_halt");

      // Reset during stall at pc_out=4 beats a simultaneous redirect
      push_range(0, 4);
      fetch_redirect = 1'b1;
      fetch_redirect_addr = 5'd0;
      cyc();
      fetch_redirect = 1'b0;
      for (int s = 0; s < 5; s++) cyc();
      chk("mr_pre_pc", 32'(fetch_pc_out), 32'd4);
      fetch_ready = 1'b0;
      cyc();
      chk("mr_stall_pc", 32'(fetch_pc_out), 32'd4);
      fetch_rst = 1'b1;
      fetch_redirect = 1'b1;
      fetch_redirect_addr = 5'd14;
      cyc();
      chk("mr_addr", 32'(fetch_addr), 32'd0);
      chk("mr_valid", 32'(fetch_valid), 32'd0);
      chk("mr_halted", 32'(fetch_halted), 32'd0);
      chk("mr_pc_out", 32'(fetch_pc_out), 32'd0);
      fetch_rst = 1'b0;
      fetch_redirect = 1'b0;
      fetch_ready = 1'b1;
      push_range(0, 7);
      cyc();
      chk("mr_idle_addr", 32'(fetch_addr), 32'd0);
      chk("mr_idle_valid", 32'(fetch_valid), 32'd0);
      cyc();
      chk("mr_first_pc", 32'(fetch_pc_out), 32'd0);
      chk("mr_first_valid", 32'(fetch_valid), 32'd1);
      wait_halt(20, "mr_halt");

      cyc();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5, the word-index width of instruction addresses (32 words).
REQ-002 SHALL have port fetch_clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port fetch_rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port fetch_addr, output, ADDRESS_WIDTH, word address driven to instruction memory, combinationally equal to the internal PC.
REQ-005 SHALL have port fetch_instr_in, input, 32, instruction word returned by memory for fetch_addr in the same cycle.
REQ-006 SHALL have port fetch_instr_out, output, 32, registered instruction offered to decode.
REQ-007 SHALL have port fetch_pc_out, output, ADDRESS_WIDTH, word address of fetch_instr_out.
REQ-008 SHALL have port fetch_valid, output, 1; fetch_instr_out and fetch_pc_out are meaningful.
REQ-009 SHALL have port fetch_ready, input, 1; decode accepts the word on a cycle with fetch_valid=1.
REQ-010 SHALL have port fetch_redirect, input, 1, a one-cycle branch/jump request.
REQ-011 SHALL have port fetch_redirect_addr, input, ADDRESS_WIDTH, the redirect target word address.
REQ-012 SHALL have port fetch_halted, output, 1, high while in state HALT.

Function
REQ-013 SHALL implement states IDLE, RUN, HALT; IDLE always moves to RUN on the next edge with no fetch.
REQ-014 SHALL define load = (!fetch_valid || fetch_ready); in RUN, with load=1 and fetch_redirect=0, SHALL, if fetch_instr_in != 0, register fetch_instr_out<=fetch_instr_in, fetch_pc_out<=PC, fetch_valid<=1, PC<=PC+1.
REQ-015 SHALL treat fetch_instr_in == 32'h0 under load in RUN as end-of-program: fetch_valid<=0, PC unchanged, state<=HALT.
REQ-016 SHALL hold PC, fetch_instr_out, fetch_pc_out and fetch_valid stable while fetch_valid=1 and fetch_ready=0 (stall); fetch_addr stable.
REQ-017 SHALL sustain one instruction per cycle with fetch_ready held high (back-to-back, no bubbles).
REQ-018 SHALL, on fetch_redirect=1 in any state, set PC<=fetch_redirect_addr, fetch_valid<=0 (flush, regardless of fetch_ready), state<=RUN; redirect has priority over load/stall/halt.
REQ-019 SHALL give redirect latency: redirect at edge n, fetch_addr=target during cycle n+1, fetch_valid=1 with fetch_pc_out=target from cycle n+2 (if target word is nonzero).
REQ-020 SHALL wrap PC modulo 2^ADDRESS_WIDTH (31+1 -> 0 for default width).
REQ-021 SHALL in HALT keep fetch_valid=0 and PC frozen; only redirect or reset leaves HALT.
REQ-022 SHALL give fetch_rst priority over fetch_redirect and all other inputs.

Reset
REQ-023 SHALL on fetch_rst=1 at an edge set PC=0, fetch_instr_out=0, fetch_pc_out=0, fetch_valid=0, state=IDLE; fetch_halted=0.
REQ-024 SHALL discard any held or in-flight instruction when reset is asserted mid-operation; first fetch after release is address 0.

Structure
REQ-025 SHALL place state encoding (IDLE/RUN/HALT), the halt word constant 32'h0 and default ADDRESS_WIDTH in shared package fetch_pkg.
REQ-026 SHALL be a single module; an optional sub-module fetch_pc_counter (load/increment/wrap) is the only natural split.

Verification
REQ-027 Reset: assert fetch_rst 2 cycles -> fetch_addr=0, fetch_valid=0, fetch_halted=0; one IDLE cycle, then fetch_addr=0 in RUN.
REQ-028 Stream: program words 0..6 nonzero, fetch_ready=1 -> fetch_pc_out 0,1,2..6 on consecutive cycles, fetch_instr_out matches each memory word.
REQ-029 Stall: drop fetch_ready 3 cycles while fetch_pc_out=2 -> outputs and fetch_addr=3 frozen; resume -> pc_out 3 next cycle, no loss/duplication.
REQ-030 Redirect: fetch_redirect=1, target 14 while pc_out=5 and ready=0 -> next cycle valid=0, fetch_addr=14; following cycle valid=1, pc_out=14, instr=memory[14].
REQ-031 Halt/wrap: word 7 = 0 -> valid drops after pc_out=6, fetch_halted=1, fetch_addr stays 7; redirect to 31 with words 31, 0 nonzero -> pc_out 31 then 0.
REQ-032 Mid-run reset: fetch_rst during stall at pc_out=4 together with redirect to 14 -> reset wins, PC=0, valid=0, restart from address 0.
